// File: rtl/i2c_master_writer.sv
// Write-only open-drain I2C master: START, command byte, streamed data bytes
// with per-byte ACK check, then STOP. No clock stretching or arbitration.
module i2c_master_writer #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        pin_scl,
    inout  wire        pin_sda,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nack
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StData, StAck, StWaitTx, StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic            last_q, last_d;
    logic            in_data_q, in_data_d;
    logic            nack_q, nack_d;
    logic            scl_low_d, sda_low_d;
    logic            scl_low_q, sda_pre_q, sda_low_q;
    logic            sda_meta_q, sda_sync_q;
    logic            tick;

    assign pin_scl = scl_low_q ? 1'b0 : 1'bz;
    assign pin_sda = sda_low_q ? 1'b0 : 1'bz;
    assign tick    = (cnt_q == CntW'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        last_d    = last_q;
        in_data_d = in_data_q;
        nack_d    = nack_q;
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        cmd_ready = 1'b0;
        tx_ready  = 1'b0;
        done      = 1'b0;
        nack      = 1'b0;
        busy      = (state_q != StIdle);

        if (state_q != StIdle) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) qtr_d = qtr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    shift_d   = cmd_addr;
                    bitcnt_d  = 3'd7;
                    last_d    = 1'b0;
                    in_data_d = 1'b0;
                    nack_d    = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                sda_low_d = 1'b1;
                scl_low_d = (qtr_q == 2'd2);
                if (tick && qtr_q == 2'd2) state_d = StAddr;
            end
            StAddr, StData: begin
                scl_low_d = !qtr_q[1];
                sda_low_d = !shift_q[7];
                if (tick && qtr_q == 2'd3) begin
                    if (bitcnt_q == 3'd0) begin
                        state_d = StAck;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q - 1'b1;
                    end
                end
            end
            StAck: begin
                scl_low_d = !qtr_q[1];
                if (tick && qtr_q == 2'd3) begin
                    if (sda_sync_q) begin
                        nack_d  = 1'b1;
                        state_d = StStop;
                    end else if (in_data_q && last_q) begin
                        state_d = StStop;
                    end else begin
                        state_d = StWaitTx;
                    end
                end
            end
            StWaitTx: begin
                scl_low_d = 1'b1;
                if (tx_valid) begin
                    tx_ready  = 1'b1;
                    shift_d   = tx_data;
                    last_d    = tx_last;
                    bitcnt_d  = 3'd7;
                    in_data_d = 1'b1;
                    state_d   = StData;
                end
            end
            StStop: begin
                // q0 pulls SDA low under SCL low so the SDA rise in q2 is a clean STOP
                scl_low_d = (qtr_q == 2'd0);
                sda_low_d = !qtr_q[1];
                if (tick && qtr_q == 2'd3) begin
                    done    = 1'b1;
                    nack    = nack_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            qtr_d = '0;
        end
    end

    // SDA trails SCL by one extra clock so data never moves on an SCL edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qtr_q      <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            last_q     <= 1'b0;
            in_data_q  <= 1'b0;
            nack_q     <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_pre_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            last_q     <= last_d;
            in_data_q  <= in_data_d;
            nack_q     <= nack_d;
            scl_low_q  <= scl_low_d;
            sda_pre_q  <= sda_low_d;
            sda_low_q  <= sda_pre_q;
            sda_meta_q <= pin_sda;
            sda_sync_q <= sda_meta_q;
        end
    end
endmodule

// File: tb/tb_i2c_master_writer.sv
// Directed bench for i2c_master_writer at CLK_DIV=4 with a behavioural
// write-only slave (address pointer auto-increments per data byte).
module tb_i2c_master_writer;
    localparam int unsigned CLK_DIV = 4;
    localparam int CLK_PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst;
    wire        scl;
    wire        sda;
    logic       cmd_valid, cmd_ready, tx_last, tx_valid, tx_ready, busy, done, nack;
    logic [7:0] cmd_addr, tx_data;

    pullup (scl);
    pullup (sda);

    i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_scl  (scl),
        .pin_sda  (sda),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .nack     (nack)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state and bus monitors
    logic       slv_present = 1'b1;
    logic       slv_drive   = 1'b0;
    int         slv_bits    = 0;
    int         slv_nbytes  = 0;
    logic [7:0] slv_sr      = 8'h00;
    logic [7:0] slv_first   = 8'h00;
    logic [7:0] slv_addr    = 8'h00;
    logic [7:0] rx_q[$];
    int         data_pulses = 0;
    int         start_cnt   = 0;
    int         stop_cnt    = 0;
    int         scl_rises   = 0;
    int         txr_cnt     = 0;
    longint     last_rise   = 0;
    longint     period      = 0;

    assign sda = slv_drive ? 1'b0 : 1'bz;

    always @(negedge sda) begin
        if (scl === 1'b1) begin
            start_cnt++;
            slv_bits   = 0;
            slv_nbytes = 0;
        end
    end

    always @(posedge sda) if (scl === 1'b1) stop_cnt++;

    always @(posedge scl) begin
        scl_rises++;
        if (scl_rises == 3) period = $time - last_rise;
        last_rise = $time;
        if (slv_bits < 8) begin
            slv_sr = {slv_sr[6:0], sda};
            slv_bits++;
        end else begin
            slv_bits = 0;
        end
    end

    always @(negedge scl) begin
        if (slv_bits == 8) begin
            if (slv_nbytes == 0) begin
                slv_first = slv_sr;
                slv_addr  = slv_sr;
            end else begin
                rx_q.push_back(slv_sr);
                slv_addr = slv_addr + 8'd1;
                data_pulses++;
            end
            slv_nbytes++;
            slv_drive = slv_present;
        end else begin
            slv_drive = 1'b0;
        end
    end

    always @(negedge clk) if (tx_ready) txr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] tx_bytes[4];
    bit         done_seen, nack_seen;
    int         stall_hi;
    int         wait_cyc;

    // One command plus n data bytes; optional stall before presenting the first byte
    task automatic xfer(input logic [7:0] a, input int n, input int stall);
        int  budget;
        int  idx;
        bit  pend;
        logic r, d, k;
        done_seen = 0; nack_seen = 0; stall_hi = 0; scl_rises = 0;
        rx_q.delete(); data_pulses = 0; start_cnt = 0; stop_cnt = 0; txr_cnt = 0;
        idx = 0; pend = 0; budget = 0;
        @(negedge clk); cmd_addr = a; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        if (stall > 0) begin
            repeat (300) @(negedge clk);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (scl !== 1'b0) stall_hi++;
            end
        end
        tx_data = tx_bytes[0]; tx_last = (n == 1); tx_valid = 1'b1;
        while (!done_seen && budget < 5000) begin
            @(negedge clk);
            budget++;
            r = tx_ready; d = done; k = nack;
            if (d) begin
                done_seen = 1;
                nack_seen = k;
            end
            if (pend) begin
                pend = 0;
                idx++;
                if (idx < n) begin
                    tx_data = tx_bytes[idx];
                    tx_last = (idx == n - 1);
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (r) pend = 1;
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        #(CLK_PERIOD * 20000);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; tx_data = '0; tx_last = 1'b0;
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_nack", nack, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single byte; SCL period 4*CLK_DIV clocks
        tx_bytes[0] = 8'hA5;
        xfer(8'h10, 1, 0);
        check("s1_done", done_seen, 1'b1);
        check("s1_nack", nack_seen, 1'b0);
        check("s1_first", slv_first, 8'h10);
        check("s1_addr", slv_addr, 8'h11);
        check("s1_pulses", data_pulses, 1);
        check("s1_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
        check("s1_period", period[31:0], 4 * CLK_DIV * CLK_PERIOD);
        check("s1_tx_ready", txr_cnt, 1);
        check("s1_starts", start_cnt, 1);
        check("s1_stops", stop_cnt, 1);

        // 2: three bytes, last on the third
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
        xfer(8'h20, 3, 0);
        check("s2_done", done_seen, 1'b1);
        check("s2_nack", nack_seen, 1'b0);
        check("s2_pulses", data_pulses, 3);
        check("s2_data0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h01);
        check("s2_data1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h02);
        check("s2_data2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'h03);
        // 4*9 clock pulses plus the SCL rise of STOP
        check("s2_scl_rises", scl_rises, 4 * 9 + 1);

        // 3: no slave, NACK on the command byte
        slv_present = 1'b0;
        tx_bytes[0] = 8'h77;
        xfer(8'h40, 1, 0);
        slv_present = 1'b1;
        check("s3_done", done_seen, 1'b1);
        check("s3_nack", nack_seen, 1'b1);
        check("s3_tx_ready", txr_cnt, 0);
        check("s3_first", slv_first, 8'h40);
        check("s3_pulses", data_pulses, 0);
        check("s3_stops", stop_cnt, 1);

        // 4: 1000-cycle stall in WAIT_TX
        tx_bytes[0] = 8'h3C;
        xfer(8'h50, 1, 1000);
        check("s4_scl_held_low", stall_hi, 0);
        check("s4_done", done_seen, 1'b1);
        check("s4_nack", nack_seen, 1'b0);
        check("s4_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);

        // 5: reset pulse during data bit 4
        @(negedge clk); cmd_addr = 8'h70; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; tx_data = 8'hC3; tx_last = 1'b1; tx_valid = 1'b1;
        wait_cyc = 0;
        while (!(slv_nbytes == 1 && slv_bits == 4) && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("s5_reached_bit4", (wait_cyc < 2000), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        check("s5_scl", scl, 1'b1);
        check("s5_sda", sda, 1'b1);
        check("s5_cmd_ready", cmd_ready, 1'b1);
        check("s5_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        tx_bytes[0] = 8'h5A;
        xfer(8'h60, 1, 0);
        check("s5_done", done_seen, 1'b1);
        check("s5_nack", nack_seen, 1'b0);
        check("s5_first", slv_first, 8'h60);
        check("s5_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
